vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter AW, default 17, framebuffer word-address width (320x240 words).
REQ-002 Parameter DW, default 8, pixel word width (RGB 3-3-2).
REQ-003 Parameter STARVE_LIM, default 255, write-head wait threshold in cycles (1..255).
REQ-004 clk_60Mhz  input  1  sole clock; all state rising-edge.
REQ-005 reset_  input  1  asynchronous, active-low reset.
REQ-006 i_rd_req  input  1  scanout read request (one word per cycle).
REQ-007 i_rd_addr  input  AW  scanout read address.
REQ-008 o_rd_valid  output  1  o_rd_data holds returned pixel.
REQ-009 o_rd_data  output  DW  returned pixel word.
REQ-010 i_wr_req  input  1  writer offers a word.
REQ-011 i_wr_addr  input  AW  writer address.
REQ-012 i_wr_data  input  DW  writer data.
REQ-013 o_wr_ready  output  1  write buffer can accept.
REQ-014 o_mem_en  output  1  SRAM access strobe.
REQ-015 o_mem_we  output  1  SRAM write enable.
REQ-016 o_mem_addr  output  AW  SRAM address.
REQ-017 o_mem_wdata  output  DW  SRAM write data.
REQ-018 i_mem_rdata  input  DW  SRAM read data, valid one cycle after o_mem_en with o_mem_we=0.
REQ-019 o_wr_starve  output  1  write head waited >= STARVE_LIM cycles.

Function
REQ-020 Scanout has absolute priority: i_rd_req high in cycle N -> read command on o_mem_* in N+1; never stalled, no grant.
REQ-021 Read latency fixed: request in N -> o_rd_valid=1 with data in N+3 (SRAM returns in N+2, registered); o_rd_valid high for exactly one cycle per request.
REQ-022 All o_mem_* registered; o_mem_en=0, o_mem_we=0, addr/wdata hold last value on idle cycles.
REQ-023 Write accepted when i_wr_req && o_wr_ready; o_wr_ready = !full (registered occupancy, no same-cycle pass-through when full).
REQ-024 Buffer head issued as write in cycle N+1 when buffer non-empty and i_rd_req low in N; pop on issue.
REQ-025 Word accepted into empty buffer in N: earliest write command N+2.
REQ-026 Simultaneous accept and pop permitted; occupancy unchanged; FIFO order preserved.
REQ-027 Arbiter FSM states IDLE, READ, WRITE = command issued next cycle; READ if i_rd_req, else WRITE if non-empty, else IDLE.
REQ-028 Wait counter 8-bit, increments each cycle buffer non-empty and head not issued, saturates 255, clears on head issue or empty.
REQ-029 o_wr_starve registered, high while wait counter >= STARVE_LIM; does not override REQ-020.
REQ-030 Address/data pass unmodified; no address arithmetic or wrap.

Reset
REQ-031 reset_ low: all outputs 0, buffer empty, wait counter 0, FSM IDLE, in-flight reads discarded (no o_rd_valid after release).
REQ-032 Reset mid-operation: buffered, unissued writes lost; o_wr_ready=1 first cycle after release.

Configuration
REQ-033 Macro FB_WR_BUF_EN defined: write buffer 4 entries, o_wr_ready=0 only with 4 held.
REQ-034 FB_WR_BUF_EN undefined: single holding register (depth 1); all other requirements unchanged.

Verification
REQ-035 Reset release, i_rd_req=1 addr 0x00010, rdata=0xA5 -> o_mem_en=1, we=0, addr 0x00010 cycle +1; o_rd_valid=1, o_rd_data=0xA5 cycle +3.
REQ-036 Idle bus, one write addr 0x12C00 data 0x3C -> o_mem_we=1, addr 0x12C00, wdata 0x3C two cycles after accept.
REQ-037 FB_WR_BUF_EN, i_rd_req held high, 5 writes offered -> 4 accepted, o_wr_ready=0, no writes issued; drop i_rd_req -> 4 writes issued in order, back-to-back.
REQ-038 i_rd_req high 300 cycles with one buffered write -> o_wr_starve=1 after 255 waits, reads unbroken; clears cycle after write issued.
REQ-039 Reset asserted with 3 buffered writes and 2 reads in flight -> no writes or o_rd_valid after release; o_wr_ready=1.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: framebuffer SRAM arbiter between VGA scanout reads and a
// buffered pixel writer. Scanout always wins; the writer's words wait in a
// small FIFO and drain on cycles with no scanout request.
// Build option: define FB_WR_BUF_EN for a 4-entry write buffer; otherwise a
// single holding register is used.
//
// Handshake: a write word transfers in any cycle where i_wr_req && o_wr_ready
// are both high. o_wr_ready depends only on registered occupancy, so it never
// looks at i_wr_req. Reads have no handshake: every i_rd_req cycle yields one
// o_rd_valid pulse exactly three cycles later.
module vga_fb_arbiter #(
    parameter int AW         = 17,
    parameter int DW         = 8,
    parameter int STARVE_LIM = 255
) (
    input  logic          clk_60Mhz,
    input  logic          reset_,
    input  logic          i_rd_req,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_valid,
    output logic [DW-1:0] o_rd_data,
    input  logic          i_wr_req,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_wr_ready,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_wr_starve,
    output logic [1:0]    o_dbg_state
);

`ifdef FB_WR_BUF_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // State names the command that is on o_mem_* this cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

    arb_state_t    state, next_state;
    logic [AW-1:0] buf_addr [0:(1<<PW)-1];
    logic [DW-1:0] buf_data [0:(1<<PW)-1];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;
    logic [7:0]    wait_cnt, wait_next;
    logic          rd_p1, rd_p2;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = i_wr_req && !full;
    assign pop   = !i_rd_req && !empty;

    // Ready is forced low while reset is held, high again as soon as it lifts.
    assign o_wr_ready  = reset_ && !full;
    assign o_dbg_state = state;

    // Choose next bus command and next wait count from this cycle's inputs.
    always_comb begin
        next_state = ST_IDLE;
        wait_next  = wait_cnt;
        if (i_rd_req)
            next_state = ST_READ;
        else if (!empty)
            next_state = ST_WRITE;
        if (empty || pop)
            wait_next = 8'd0;
        else if (wait_cnt != 8'hFF)
            wait_next = wait_cnt + 8'd1;
    end

    // Write buffer storage; contents are don't-care until occupancy says so.
    always_ff @(posedge clk_60Mhz) begin
        if (push) begin
            buf_addr[wr_ptr] <= i_wr_addr;
            buf_data[wr_ptr] <= i_wr_data;
        end
    end

    // Arbiter FSM, FIFO bookkeeping, registered SRAM command and read return.
    always_ff @(posedge clk_60Mhz or negedge reset_) begin
        if (!reset_) begin
            state       <= ST_IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            wait_cnt    <= 8'd0;
            o_wr_starve <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            rd_p1       <= 1'b0;
            rd_p2       <= 1'b0;
            o_rd_valid  <= 1'b0;
            o_rd_data   <= '0;
        end else begin
            state       <= next_state;
            wait_cnt    <= wait_next;
            o_wr_starve <= (int'(wait_next) >= STARVE_LIM);

            case (next_state)
                ST_READ: begin
                    o_mem_en   <= 1'b1;
                    o_mem_we   <= 1'b0;
                    o_mem_addr <= i_rd_addr;
                end
                ST_WRITE: begin
                    o_mem_en    <= 1'b1;
                    o_mem_we    <= 1'b1;
                    o_mem_addr  <= buf_addr[rd_ptr];
                    o_mem_wdata <= buf_data[rd_ptr];
                end
                default: begin
                    o_mem_en <= 1'b0;
                    o_mem_we <= 1'b0;
                end
            endcase

            if (push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Request -> command on bus -> SRAM data on i_mem_rdata -> registered out.
            rd_p1      <= i_rd_req;
            rd_p2      <= rd_p1;
            o_rd_valid <= rd_p2;
            if (rd_p2)
                o_rd_data <= i_mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model through expected-response queues.
module tb_vga_fb_arbiter;

`ifdef FB_WR_BUF_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int LIM = 255;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        i_rd_req = 1'b0;
  logic [16:0] i_rd_addr = '0;
  logic        i_wr_req = 1'b0;
  logic [16:0] i_wr_addr = '0;
  logic [7:0]  i_wr_data = '0;
  logic [7:0]  i_mem_rdata = '0;
  logic        o_rd_valid, o_wr_ready, o_mem_en, o_mem_we, o_wr_starve;
  logic [7:0]  o_rd_data, o_mem_wdata;
  logic [16:0] o_mem_addr;
  logic [1:0]  o_dbg_state;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.AW(17), .DW(8), .STARVE_LIM(LIM)) dut (
    .clk_60Mhz   (clk),
    .reset_      (reset_),
    .i_rd_req    (i_rd_req),
    .i_rd_addr   (i_rd_addr),
    .o_rd_valid  (o_rd_valid),
    .o_rd_data   (o_rd_data),
    .i_wr_req    (i_wr_req),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .o_wr_ready  (o_wr_ready),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_wr_starve (o_wr_starve),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- SRAM model ----------------
  // Content is a fixed function of address, so read data is predictable.
  // sram_f(17'h00010) = 8'hA5.
  function automatic logic [7:0] sram_f(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'hB5;
  endfunction

  logic        pend_rd = 1'b0;
  logic [16:0] pend_addr = '0;

  always @(negedge clk) begin
    pend_rd   = o_mem_en && !o_mem_we;
    pend_addr = o_mem_addr;
  end

  always @(posedge clk) begin
    #1;
    i_mem_rdata = pend_rd ? sram_f(pend_addr) : 8'($urandom);
  end

  // ---------------- scoreboard state ----------------
  logic [57:0] exp_mem_q[$];   // {cycle[31:0], we, addr[16:0], data[7:0]}
  logic [39:0] exp_rd_q[$];    // {cycle[31:0], data[7:0]}
  logic [24:0] model_q[$];     // {addr, data} words held by the writer buffer
  int          model_wait = 0;
  logic        exp_ready = 1'b0;
  logic        exp_starve = 1'b0;
  logic        exp_starve_next = 1'b0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          n_vec = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver + reference model ----------------
  task automatic drive(input logic rst, input logic rd, input logic [16:0] ra,
                       input logic wr, input logic [16:0] wa, input logic [7:0] wd);
    logic        nonempty;
    logic        issued;
    logic [24:0] head;
    @(posedge clk);
    cyc++;
    #1;
    reset_    = !rst;
    i_rd_req  = rd;
    i_rd_addr = ra;
    i_wr_req  = wr;
    i_wr_addr = wa;
    i_wr_data = wd;
    mon_en    = 1'b1;
    if (rst) begin
      exp_mem_q.delete();
      exp_rd_q.delete();
      model_q.delete();
      model_wait      = 0;
      exp_ready       = 1'b0;
      exp_starve      = 1'b0;
      exp_starve_next = 1'b0;
      return;
    end
    exp_starve = exp_starve_next;
    exp_ready  = (model_q.size() < DEPTH);
    nonempty   = (model_q.size() != 0);
    issued     = 1'b0;
    if (rd) begin
      exp_mem_q.push_back({32'(cyc + 1), 1'b0, ra, 8'h00});
      exp_rd_q.push_back({32'(cyc + 3), sram_f(ra)});
    end else if (nonempty) begin
      head = model_q.pop_front();
      exp_mem_q.push_back({32'(cyc + 1), 1'b1, head});
      issued = 1'b1;
    end
    if (wr && exp_ready)
      model_q.push_back({wa, wd});
    if (!nonempty || issued)
      model_wait = 0;
    else if (model_wait < 255)
      model_wait++;
    exp_starve_next = (model_wait >= LIM);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic rand_cycle(input int rd_pct, input int wr_pct);
    drive(1'b0, ($urandom_range(0, 99) < rd_pct), 17'($urandom),
          ($urandom_range(0, 99) < wr_pct), 17'($urandom), 8'($urandom));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [57:0] em;
    logic [39:0] er;
    if (mon_en) begin
      check("wr_ready", o_wr_ready, exp_ready);
      check("wr_starve", o_wr_starve, exp_starve);
      if (!reset_) begin
        check("reset_mem_addr", o_mem_addr, 0);
        check("reset_mem_wdata", o_mem_wdata, 0);
        check("reset_rd_data", o_rd_data, 0);
      end

      while (exp_mem_q.size() != 0 && int'(exp_mem_q[0][57:26]) < cyc) begin
        em = exp_mem_q.pop_front();
        check("mem_cmd_missing", 0, 1);
      end
      if (exp_mem_q.size() != 0 && int'(exp_mem_q[0][57:26]) == cyc) begin
        em = exp_mem_q.pop_front();
        check("mem_en", o_mem_en, 1);
        check("mem_we", o_mem_we, em[25]);
        check("mem_addr", o_mem_addr, em[24:8]);
        if (em[25]) check("mem_wdata", o_mem_wdata, em[7:0]);
      end else begin
        check("mem_en_idle", o_mem_en, 0);
        check("mem_we_idle", o_mem_we, 0);
      end

      while (exp_rd_q.size() != 0 && int'(exp_rd_q[0][39:8]) < cyc) begin
        er = exp_rd_q.pop_front();
        check("rd_valid_missing", 0, 1);
      end
      if (exp_rd_q.size() != 0 && int'(exp_rd_q[0][39:8]) == cyc) begin
        er = exp_rd_q.pop_front();
        check("rd_valid", o_rd_valid, 1);
        check("rd_data", o_rd_data, er[7:0]);
      end else begin
        check("rd_valid_idle", o_rd_valid, 0);
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    // Reset, then single scanout read of address 0x00010 (data 0xA5).
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 17'h00010, 1'b0, '0, '0);
    idle(4);

    // Single write into an idle bus.
    drive(1'b0, 1'b0, '0, 1'b1, 17'h12C00, 8'h3C);
    idle(4);

    // Scanout held high while the writer offers five words, then released.
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b1, 17'(16'h0100 + i), 1'b1, 17'(17'h01000 + i), 8'(8'h40 + i));
    idle(8);

    // One buffered write starved by 300 cycles of continuous scanout.
    drive(1'b0, 1'b1, 17'h00020, 1'b1, 17'h0ABCD, 8'h77);
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 17'(i), 1'b0, '0, '0);
    idle(5);

    // Mixed random traffic at several read/write densities.
    for (int i = 0; i < 600; i++) rand_cycle(40, 60);
    for (int i = 0; i < 600; i++) rand_cycle(80, 90);
    for (int i = 0; i < 600; i++) rand_cycle(10, 30);

    // Reset with buffered writes and reads in flight.
    idle(4);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 17'(17'h00300 + i), 1'b1, 17'(17'h02000 + i), 8'(8'h90 + i));
    drive(1'b0, 1'b1, 17'h00400, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 17'h00401, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
    idle(6);

    for (int i = 0; i < 500; i++) rand_cycle(50, 50);
    idle(8);

    check("mem_q_drained", exp_mem_q.size(), 0);
    check("rd_q_drained", exp_rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
